pc_fetch_ctrl: RTL and testbench

- Drives the program counter forward and fetches instructions from instruction memory.
- Sits between the PC register path and the decode stage:
  - generates the next-PC sequence itself (+4 increment or redirect);
  - issues request/grant/response transactions to instruction memory;
  - presents each fetched word to decode with a valid/ready handshake.

---
 rtl/rv_fetch_pkg.sv | 18 +
 rtl/pc_fetch_ctrl_if.sv | 45 ++++
 rtl/pc_fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared definitions for the instruction fetch controller.
//   fetch_state_e : FSM state encoding (3-bit).
//   NOP_INSTR     : word presented to decode while no instruction has been fetched.
//   PC_STEP       : sequential PC increment in bytes.
package rv_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: bus bundle between the fetch controller and its environment.
//   redirect_valid/redirect_pc : branch/jump redirect from execute
//   imem_req/imem_addr         : request to instruction memory
//   imem_gnt                   : request accepted
//   imem_rvalid/imem_rdata     : read response
//   instr_valid/instr/instr_pc : fetched word towards decode
//   instr_ready                : decode accepts the word
//   fetch_misalign             : misaligned-redirect pulse
// Modports: master = fetch controller, slave = memory/decode/execute side.
interface pc_fetch_ctrl_if #(
  parameter int XLEN = 32
);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            fetch_misalign;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    output fetch_misalign
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    input  fetch_misalign
  );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter sequencing and instruction fetch.
// Issues one request/grant/response transaction per instruction to instruction
// memory and holds each fetched word for decode under a valid/ready handshake.
// Ports:
//   clk_if : clock, rising edge
//   rst_if : asynchronous active-low reset
//   bus    : pc_fetch_ctrl_if.master (redirect, imem and decode signals)
// Parameters: XLEN (PC/instruction width), RESET_PC (PC after reset).
// Build option: FETCH_MISALIGN_EN - when defined, a redirect to a target with
// nonzero low bits is rejected and flagged on fetch_misalign; when undefined,
// the low two target bits are cleared and fetch_misalign is held 0.
//
// state | meaning
// IDLE  | out of reset, first request issued next cycle
// REQ   | imem_req high at pc, waiting for grant
// WAIT  | granted, waiting for read data
// HOLD  | instruction presented to decode, waiting for instr_ready
// DROP  | redirected with a response still outstanding; discard it
module pc_fetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk_if,
  input  logic                rst_if,
  pc_fetch_ctrl_if.master     bus
);

  fetch_state_e    state_q, state_nxt;
  logic [XLEN-1:0] pc_q, pc_nxt;
  logic [XLEN-1:0] instr_q, instr_nxt;
  logic [XLEN-1:0] instr_pc_q, instr_pc_nxt;
  logic            instr_valid_q, instr_valid_nxt;

  // redir: a redirect that actually takes effect; redir_tgt: the pc it loads.
  logic            redir;
  logic [XLEN-1:0] redir_tgt;

`ifdef FETCH_MISALIGN_EN
  logic misalign_hit;
  logic misalign_q;

  // A misaligned target is swallowed entirely: fetch proceeds as if no
  // redirect had been seen, only the flag is raised.
  assign misalign_hit = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign redir        = bus.redirect_valid && !misalign_hit;
  assign redir_tgt    = bus.redirect_pc;

  always_ff @(posedge clk_if or negedge rst_if) begin
    if (!rst_if) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_hit;
    end
  end

  assign bus.fetch_misalign = misalign_q;
`else
  logic unused_redirect_lsb;

  assign redir               = bus.redirect_valid;
  assign redir_tgt           = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
  assign bus.fetch_misalign  = 1'b0;
`endif

  always_ff @(posedge clk_if or negedge rst_if) begin
    if (!rst_if) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= XLEN'(NOP_INSTR);
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      pc_q          <= pc_nxt;
      instr_q       <= instr_nxt;
      instr_pc_q    <= instr_pc_nxt;
      instr_valid_q <= instr_valid_nxt;
    end
  end

  always_comb begin
    state_nxt       = state_q;
    pc_nxt          = pc_q;
    instr_nxt       = instr_q;
    instr_pc_nxt    = instr_pc_q;
    instr_valid_nxt = instr_valid_q;

    // Redirect always loads pc and kills any word held for decode; the
    // state it leads to depends on whether a response is still in flight.
    if (redir) begin
      pc_nxt          = redir_tgt;
      instr_valid_nxt = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        state_nxt = ST_REQ;
      end

      ST_REQ: begin
        if (redir) begin
          state_nxt = bus.imem_gnt ? ST_DROP : ST_REQ;
        end else if (bus.imem_gnt) begin
          state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redir) begin
          state_nxt = bus.imem_rvalid ? ST_REQ : ST_DROP;
        end else if (bus.imem_rvalid) begin
          instr_nxt       = bus.imem_rdata;
          instr_pc_nxt    = pc_q;
          instr_valid_nxt = 1'b1;
          state_nxt       = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (redir) begin
          state_nxt = ST_REQ;
        end else if (bus.instr_ready) begin
          instr_valid_nxt = 1'b0;
          pc_nxt          = pc_q + XLEN'(PC_STEP);
          state_nxt       = ST_REQ;
        end
      end

      ST_DROP: begin
        // A redirect here only retargets pc; the outstanding response is
        // still the one to discard.
        if (bus.imem_rvalid) begin
          state_nxt = ST_REQ;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.imem_req    = (state_q == ST_REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed bench for pc_fetch_ctrl.
// dut0 runs with RESET_PC=0, dut1 with RESET_PC=32'hFFFF_FFFC (wrap case).
module tb_pc_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk_sys = 1'b0;
  logic rst_b   = 1'b0;

  always #5 clk_sys = ~clk_sys;

  pc_fetch_ctrl_if #(.XLEN(32)) bus0 ();
  pc_fetch_ctrl_if #(.XLEN(32)) bus1 ();

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut0 (
    .clk_if (clk_sys),
    .rst_if (rst_b),
    .bus    (bus0.master)
  );

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk_if (clk_sys),
    .rst_if (rst_b),
    .bus    (bus1.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.redirect_valid = 0; bus0.redirect_pc = '0; bus0.imem_gnt = 0;
    bus0.imem_rvalid = 0; bus0.imem_rdata = '0; bus0.instr_ready = 0;
    bus1.redirect_valid = 0; bus1.redirect_pc = '0; bus1.imem_gnt = 0;
    bus1.imem_rvalid = 0; bus1.imem_rdata = '0; bus1.instr_ready = 0;

    // reset values
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_req",      32'(bus0.imem_req), 32'd0);
    chk("rst_valid",    32'(bus0.instr_valid), 32'd0);
    chk("rst_instr",    bus0.instr, NOP);
    chk("rst_instr_pc", bus0.instr_pc, 32'h0);
    chk("rst_misalign", 32'(bus0.fetch_misalign), 32'd0);
    chk("rst1_instr_pc", bus1.instr_pc, 32'hFFFF_FFFC);

    rst_b = 1'b1;
    clk1();  // IDLE -> REQ
    chk("req0_req",  32'(bus0.imem_req), 32'd1);
    chk("req0_addr", bus0.imem_addr, 32'h0);

    // fetch at 0, zero-wait memory
    bus0.imem_gnt = 1;
    clk1();
    chk("wait0_req", 32'(bus0.imem_req), 32'd0);
    bus0.imem_gnt = 0; bus0.imem_rvalid = 1; bus0.imem_rdata = 32'h0050_0093;
    clk1();
    bus0.imem_rvalid = 0;
    chk("hold0_valid", 32'(bus0.instr_valid), 32'd1);
    chk("hold0_instr", bus0.instr, 32'h0050_0093);
    chk("hold0_pc",    bus0.instr_pc, 32'h0);

    // decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      clk1();
      chk("stall_valid", 32'(bus0.instr_valid), 32'd1);
      chk("stall_instr", bus0.instr, 32'h0050_0093);
      chk("stall_pc",    bus0.instr_pc, 32'h0);
      chk("stall_req",   32'(bus0.imem_req), 32'd0);
      chk("stall_addr",  bus0.imem_addr, 32'h0);
    end

    bus0.instr_ready = 1;
    clk1();
    bus0.instr_ready = 0;
    chk("req4_addr",  bus0.imem_addr, 32'h4);
    chk("req4_req",   32'(bus0.imem_req), 32'd1);
    chk("req4_valid", 32'(bus0.instr_valid), 32'd0);

    // fetch at 4
    bus0.imem_gnt = 1;
    clk1();
    bus0.imem_gnt = 0; bus0.imem_rvalid = 1; bus0.imem_rdata = 32'h00A0_0113;
    clk1();
    bus0.imem_rvalid = 0;
    chk("hold4_pc",    bus0.instr_pc, 32'h4);
    chk("hold4_instr", bus0.instr, 32'h00A0_0113);
    bus0.instr_ready = 1;
    clk1();
    bus0.instr_ready = 0;
    chk("req8_addr", bus0.imem_addr, 32'h8);

    // redirect coinciding with grant at 8 -> DROP
    bus0.imem_gnt = 1; bus0.redirect_valid = 1; bus0.redirect_pc = 32'h100;
    clk1();
    bus0.imem_gnt = 0; bus0.redirect_valid = 0;
    chk("drop_req",   32'(bus0.imem_req), 32'd0);
    chk("drop_valid", 32'(bus0.instr_valid), 32'd0);
    chk("drop_addr",  bus0.imem_addr, 32'h100);
    clk1();
    chk("drop_wait_req", 32'(bus0.imem_req), 32'd0);
    bus0.imem_rvalid = 1; bus0.imem_rdata = 32'hDEAD_BEEF;
    clk1();
    bus0.imem_rvalid = 0;
    chk("post_drop_valid", 32'(bus0.instr_valid), 32'd0);
    chk("post_drop_instr", bus0.instr, 32'h00A0_0113);
    chk("post_drop_req",   32'(bus0.imem_req), 32'd1);
    chk("post_drop_addr",  bus0.imem_addr, 32'h100);

    // misaligned redirect while in REQ
    bus0.redirect_valid = 1; bus0.redirect_pc = 32'h102;
    clk1();
    bus0.redirect_valid = 0;
    chk("mis_addr", bus0.imem_addr, 32'h100);
    chk("mis_req",  32'(bus0.imem_req), 32'd1);
`ifdef FETCH_MISALIGN_EN
    chk("mis_flag", 32'(bus0.fetch_misalign), 32'd1);
`else
    chk("mis_flag", 32'(bus0.fetch_misalign), 32'd0);
`endif
    clk1();
    chk("mis_flag_clr", 32'(bus0.fetch_misalign), 32'd0);

    // redirect beats instr_ready in HOLD
    bus0.imem_gnt = 1;
    clk1();
    bus0.imem_gnt = 0; bus0.imem_rvalid = 1; bus0.imem_rdata = 32'h1234_5678;
    clk1();
    bus0.imem_rvalid = 0;
    chk("hold100_pc", bus0.instr_pc, 32'h100);
    bus0.instr_ready = 1; bus0.redirect_valid = 1; bus0.redirect_pc = 32'h200;
    clk1();
    bus0.instr_ready = 0; bus0.redirect_valid = 0;
    chk("hold_redir_addr",  bus0.imem_addr, 32'h200);
    chk("hold_redir_valid", 32'(bus0.instr_valid), 32'd0);
    chk("hold_redir_req",   32'(bus0.imem_req), 32'd1);

    // redirect with rvalid in WAIT -> response discarded, straight to REQ
    bus0.imem_gnt = 1;
    clk1();
    bus0.imem_gnt = 0; bus0.imem_rvalid = 1; bus0.imem_rdata = 32'h1111_1111;
    bus0.redirect_valid = 1; bus0.redirect_pc = 32'h300;
    clk1();
    bus0.imem_rvalid = 0; bus0.redirect_valid = 0;
    chk("wait_redir_addr",  bus0.imem_addr, 32'h300);
    chk("wait_redir_req",   32'(bus0.imem_req), 32'd1);
    chk("wait_redir_valid", 32'(bus0.instr_valid), 32'd0);
    chk("wait_redir_instr", bus0.instr, 32'h1234_5678);

    // reset asserted while in WAIT
    bus0.imem_gnt = 1;
    clk1();
    bus0.imem_gnt = 0;
    chk("pre_rst_req", 32'(bus0.imem_req), 32'd0);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_req",   32'(bus0.imem_req), 32'd0);
    chk("arst_valid", 32'(bus0.instr_valid), 32'd0);
    chk("arst_instr", bus0.instr, NOP);
    chk("arst_pc",    bus0.instr_pc, 32'h0);
    chk("arst_addr",  bus0.imem_addr, 32'h0);
    bus0.imem_rvalid = 1; bus0.imem_rdata = 32'h2222_2222;  // late response
    @(negedge clk_sys);
    rst_b = 1'b1;
    clk1();
    bus0.imem_rvalid = 0;
    chk("rel_req",   32'(bus0.imem_req), 32'd1);
    chk("rel_addr",  bus0.imem_addr, 32'h0);
    chk("rel_valid", 32'(bus0.instr_valid), 32'd0);
    clk1();
    chk("rel_hold_req", 32'(bus0.imem_req), 32'd1);

    // dut1: wrap from 0xFFFF_FFFC
    chk("wrap_start_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    bus1.imem_gnt = 1;
    clk1();
    bus1.imem_gnt = 0; bus1.imem_rvalid = 1; bus1.imem_rdata = 32'h0000_0073;
    clk1();
    bus1.imem_rvalid = 0;
    chk("wrap_hold_pc", bus1.instr_pc, 32'hFFFF_FFFC);
    bus1.instr_ready = 1;
    clk1();
    bus1.instr_ready = 0;
    chk("wrap_addr", bus1.imem_addr, 32'h0);
    chk("wrap_req",  32'(bus1.imem_req), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
